pllvr_dyn_ctrl: RTL and testbench

Sequencer that sits directly upstream of the Gowin PLLVR wrapper and drives its dynamic divider inputs (`fdiv`, `idiv`) and its active-high `reset`. It accepts divider-change requests over a valid/ready handshake and then runs a fixed sequence: hold the PLL in reset, release it, and wait for a qualified lock. It reports `locked` on success, or a sticky `err` if lock is not achieved within a timeout. It runs in the PLL reference-clock domain (27 MHz crystal).

---
 rtl/pllvr_dyn_ctrl_if.sv | 10 +
 rtl/pllvr_dyn_ctrl.sv | 129 ++++++++++++
 tb/tb_pllvr_dyn_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/pllvr_dyn_ctrl_if.sv
// Divider-change request channel into the PLLVR sequencer (valid/ready with codes).
interface pllvr_dyn_ctrl_if;
  logic       valid;
  logic       ready;
  logic [5:0] fdiv;
  logic [5:0] idiv;

  modport master (output valid, output fdiv, output idiv, input ready);
  modport slave  (input valid, input fdiv, input idiv, output ready);
endinterface

// File: rtl/pllvr_dyn_ctrl.sv
// PLLVR dynamic divider sequencer: latch new codes, hold PLL in reset, then
// wait for a qualified lock or time out into a sticky error state.
module pllvr_dyn_ctrl #(
  parameter int         RESET_CYCLES = 16,
  parameter int         LOCK_STABLE  = 8,
  parameter int         LOCK_TIMEOUT = 65535,
  parameter logic [5:0] INIT_FDIV    = 6'd0,
  parameter logic [5:0] INIT_IDIV    = 6'd0
) (
  input  logic                   i_clkin,
  input  logic                   i_resetn,
  pllvr_dyn_ctrl_if.slave        req,
  input  logic                   i_pll_lock,
  output logic                   o_pll_reset,
  output logic [5:0]             o_fdiv,
  output logic [5:0]             o_idiv,
  output logic                   o_locked,
  output logic                   o_err
);
  localparam int RCW = $clog2(RESET_CYCLES + 1);
  localparam int STW = $clog2(LOCK_STABLE + 1);
  localparam int TOW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [RCW-1:0] RC_LAST = RCW'(RESET_CYCLES - 1);
  localparam logic [STW-1:0] ST_MAX  = STW'(LOCK_STABLE);
  localparam logic [TOW-1:0] TO_MAX  = TOW'(LOCK_TIMEOUT);

  typedef enum logic [1:0] {S_RST, S_WAIT, S_LOCKED, S_FAIL} state_t;

  state_t         r_state;
  logic [1:0]     r_sync;
  logic [RCW-1:0] r_rst_cnt;
  logic [STW-1:0] r_st_cnt;
  logic [TOW-1:0] r_to_cnt;
  logic           r_pll_reset;
  logic [5:0]     r_fdiv;
  logic [5:0]     r_idiv;
  logic           r_locked;
  logic           r_err;
  logic           r_ready;

  logic           w_lock_s;
  logic           w_accept;
  logic [STW-1:0] w_st_nxt;

  assign w_lock_s = r_sync[1];
  assign w_accept = req.valid && r_ready;
  // Stable run length including this cycle; any low sample restarts the run.
  assign w_st_nxt = !w_lock_s ? '0 : ((r_st_cnt == ST_MAX) ? r_st_cnt : r_st_cnt + 1'b1);

  always_ff @(posedge i_clkin) begin
    if (!i_resetn) begin
      r_state     <= S_RST;
      r_sync      <= 2'b00;
      r_rst_cnt   <= '0;
      r_st_cnt    <= '0;
      r_to_cnt    <= '0;
      r_pll_reset <= 1'b1;
      r_fdiv      <= INIT_FDIV;
      r_idiv      <= INIT_IDIV;
      r_locked    <= 1'b0;
      r_err       <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_pll_lock};
      // A request beats a same-cycle lock drop, so only one sequence runs.
      if (w_accept) begin
        r_state     <= S_RST;
        r_fdiv      <= req.fdiv;
        r_idiv      <= req.idiv;
        r_rst_cnt   <= '0;
        r_st_cnt    <= '0;
        r_to_cnt    <= '0;
        r_pll_reset <= 1'b1;
        r_locked    <= 1'b0;
        r_err       <= 1'b0;
        r_ready     <= 1'b0;
      end else begin
        case (r_state)
          S_RST: begin
            r_st_cnt <= '0;
            r_to_cnt <= '0;
            if (r_rst_cnt == RC_LAST) begin
              r_state     <= S_WAIT;
              r_rst_cnt   <= '0;
              r_pll_reset <= 1'b0;
            end else begin
              r_rst_cnt <= r_rst_cnt + 1'b1;
            end
          end
          S_WAIT: begin
            r_st_cnt <= w_st_nxt;
            if (r_to_cnt != TO_MAX) r_to_cnt <= r_to_cnt + 1'b1;
            if (w_st_nxt == ST_MAX) begin
              r_state  <= S_LOCKED;
              r_locked <= 1'b1;
              r_ready  <= 1'b1;
            end else if (r_to_cnt == TO_MAX) begin
              r_state     <= S_FAIL;
              r_err       <= 1'b1;
              r_pll_reset <= 1'b1;
              r_ready     <= 1'b1;
            end
          end
          S_LOCKED: begin
            if (!w_lock_s) begin
              r_state     <= S_RST;
              r_rst_cnt   <= '0;
              r_pll_reset <= 1'b1;
              r_locked    <= 1'b0;
              r_ready     <= 1'b0;
            end
          end
          S_FAIL: begin
            r_pll_reset <= 1'b1;
            r_err       <= 1'b1;
          end
          default: r_state <= S_RST;
        endcase
      end
    end
  end

  assign req.ready   = r_ready;
  assign o_pll_reset = r_pll_reset;
  assign o_fdiv      = r_fdiv;
  assign o_idiv      = r_idiv;
  assign o_locked    = r_locked;
  assign o_err       = r_err;
endmodule

// File: tb/tb_pllvr_dyn_ctrl.sv
// Bench for pllvr_dyn_ctrl: vector table, directed corner sequences, then
// random traffic checked against a timeline model of the sequencing rules.
module tb_pllvr_dyn_ctrl;
  localparam int R  = 4;
  localparam int LS = 3;
  localparam int T  = 20;
  localparam logic [5:0] IF0 = 6'd51;
  localparam logic [5:0] II0 = 6'd58;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic lk = 1'b0;
  logic o_pll_reset, o_locked, o_err;
  logic [5:0] o_fdiv, o_idiv;

  pllvr_dyn_ctrl_if rq();

  pllvr_dyn_ctrl #(
    .RESET_CYCLES(R), .LOCK_STABLE(LS), .LOCK_TIMEOUT(T),
    .INIT_FDIV(IF0), .INIT_IDIV(II0)
  ) dut (
    .i_clkin(clk), .i_resetn(rstn), .req(rq),
    .i_pll_lock(lk), .o_pll_reset(o_pll_reset),
    .o_fdiv(o_fdiv), .o_idiv(o_idiv),
    .o_locked(o_locked), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit mchk = 1'b0;

  typedef struct {
    bit rstn; bit vld; bit [5:0] rf; bit [5:0] ri; bit lk;
    bit prst; bit lkd; bit rdy; bit err; bit [5:0] f; bit [5:0] i;
  } vec_t;
  vec_t tbl[17];

  // Timeline model: phase plus the edge it was entered on, and pll_lock history.
  typedef enum {P_RST, P_WAIT, P_LCK, P_FAIL} ph_t;
  ph_t m_ph = P_RST;
  int m_t0 = 0;
  bit [5:0] m_f = IF0, m_i = II0;
  bit lkh [0:8191];

  function automatic vec_t mk(bit a, bit v, bit [5:0] rf, bit [5:0] ri, bit l,
                              bit p, bit k, bit r, bit e, bit [5:0] f, bit [5:0] i);
    vec_t x;
    x.rstn = a; x.vld = v; x.rf = rf; x.ri = ri; x.lk = l;
    x.prst = p; x.lkd = k; x.rdy = r; x.err = e; x.f = f; x.i = i;
    return x;
  endfunction

  function automatic logic [15:0] dvec();
    return {o_pll_reset, o_locked, rq.ready, o_err, o_fdiv, o_idiv};
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 20) $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic m_step();
    int n;
    int run;
    bit ls;
    n = cyc;
    if (!rstn) begin
      lkh[n] = 1'b0;
      if (n > 0) lkh[n-1] = 1'b0;
      m_ph = P_RST; m_t0 = n; m_f = IF0; m_i = II0;
    end else begin
      lkh[n] = lk;
      ls = (n >= 2) ? lkh[n-2] : 1'b0;
      if (rq.valid && (m_ph == P_LCK || m_ph == P_FAIL)) begin
        m_ph = P_RST; m_t0 = n; m_f = rq.fdiv; m_i = rq.idiv;
      end else begin
        case (m_ph)
          P_RST: if (n - m_t0 == R) begin m_ph = P_WAIT; m_t0 = n; end
          P_WAIT: begin
            run = 0;
            for (int j = n - 2; j >= m_t0 - 1 && run < LS; j--) begin
              if (!lkh[j]) break;
              run++;
            end
            if (run >= LS) m_ph = P_LCK;
            else if (n - m_t0 == T + 1) m_ph = P_FAIL;
          end
          P_LCK: if (!ls) begin m_ph = P_RST; m_t0 = n; end
          default: ;
        endcase
      end
    end
  endtask

  function automatic logic [15:0] mvec();
    return {(m_ph == P_RST || m_ph == P_FAIL), (m_ph == P_LCK),
            (m_ph == P_LCK || m_ph == P_FAIL), (m_ph == P_FAIL), m_f, m_i};
  endfunction

  task automatic tick();
    @(posedge clk);
    m_step();
    cyc++;
    #1;
    if (mchk) chk("model", dvec(), mvec());
  endtask

  task automatic wait_locked(string nm, int maxc, output int n);
    n = 0;
    while (!o_locked && n < maxc) begin tick(); n++; end
    chk(nm, o_locked, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    rq.valid = 1'b0; rq.fdiv = '0; rq.idiv = '0;

    // Power-up, ignored requests while sequencing, lock, then a retune.
    tbl[0]  = mk(0,0, 0, 0,0, 1,0,0,0,51,58);
    tbl[1]  = mk(1,0, 0, 0,0, 1,0,0,0,51,58);
    tbl[2]  = mk(1,0, 0, 0,0, 1,0,0,0,51,58);
    tbl[3]  = mk(1,0, 0, 0,0, 1,0,0,0,51,58);
    tbl[4]  = mk(1,0, 0, 0,0, 0,0,0,0,51,58);
    tbl[5]  = mk(1,1, 7, 7,0, 0,0,0,0,51,58);
    tbl[6]  = mk(1,1, 7, 7,0, 0,0,0,0,51,58);
    tbl[7]  = mk(1,0, 0, 0,0, 0,0,0,0,51,58);
    tbl[8]  = mk(1,0, 0, 0,0, 0,0,0,0,51,58);
    tbl[9]  = mk(1,0, 0, 0,1, 0,0,0,0,51,58);
    tbl[10] = mk(1,0, 0, 0,1, 0,0,0,0,51,58);
    tbl[11] = mk(1,0, 0, 0,1, 0,0,0,0,51,58);
    tbl[12] = mk(1,0, 0, 0,1, 0,0,0,0,51,58);
    tbl[13] = mk(1,0, 0, 0,1, 0,1,1,0,51,58);
    tbl[14] = mk(1,0, 0, 0,1, 0,1,1,0,51,58);
    tbl[15] = mk(1,1,12, 5,1, 1,0,0,0,12, 5);
    tbl[16] = mk(1,0, 0, 0,1, 1,0,0,0,12, 5);

    for (int k = 0; k < 17; k++) begin
      rstn = tbl[k].rstn; rq.valid = tbl[k].vld; rq.fdiv = tbl[k].rf;
      rq.idiv = tbl[k].ri; lk = tbl[k].lk;
      tick();
      chk($sformatf("tbl[%0d]", k), dvec(),
          {tbl[k].prst, tbl[k].lkd, tbl[k].rdy, tbl[k].err, tbl[k].f, tbl[k].i});
    end

    wait_locked("retune_relock", 20, n);
    chk("retune_relock_cycles", n, 6);
    chk("retune_codes", {o_fdiv, o_idiv}, {6'd12, 6'd5});

    // One-cycle lock drop: locked falls on the third edge, codes kept.
    lk = 1'b0; tick(); chk("loss_e1", o_locked, 1);
    lk = 1'b1; tick(); chk("loss_e2", o_locked, 1);
    tick();          chk("loss_e3", dvec(), {1'b1, 1'b0, 1'b0, 1'b0, 6'd12, 6'd5});
    wait_locked("loss_relock", 30, n);
    chk("loss_relock_cycles", n, 7);

    // Glitchy lock: run of two is not enough, run of three locks.
    rq.valid = 1'b1; rq.fdiv = 6'd20; rq.idiv = 6'd3; lk = 1'b0;
    tick(); chk("glitch_accept", dvec(), {1'b1, 1'b0, 1'b0, 1'b0, 6'd20, 6'd3});
    rq.valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      lk = (k <= 4 || k == 7) ? 1'b0 : 1'b1;
      tick();
      chk($sformatf("glitch_k%0d", k), o_locked, (k >= 12) ? 1 : 0);
    end

    // Request on the same cycle as a lock drop, then lock never comes.
    lk = 1'b0; tick(); chk("race_e1", o_locked, 1);
    tick();          chk("race_e2", o_locked, 1);
    rq.valid = 1'b1; rq.fdiv = 6'd9; rq.idiv = 6'd9;
    tick(); chk("race_accept", dvec(), {1'b1, 1'b0, 1'b0, 1'b0, 6'd9, 6'd9});
    rq.valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin tick(); chk("race_prst_hi", o_pll_reset, 1); end
    tick(); chk("race_prst_fall", o_pll_reset, 0);
    for (int k = 0; k < T; k++) tick();
    chk("timeout_before", o_err, 0);
    tick(); chk("timeout_err", dvec(), {1'b1, 1'b0, 1'b1, 1'b1, 6'd9, 6'd9});
    rq.valid = 1'b1; rq.fdiv = 6'd33; rq.idiv = 6'd44;
    tick(); chk("timeout_clear", dvec(), {1'b1, 1'b0, 1'b0, 1'b0, 6'd33, 6'd44});
    rq.valid = 1'b0;

    // Reset during WAIT after a retune reverts to the INIT codes.
    lk = 1'b1;
    wait_locked("pre_midrst_lock", 30, n);
    rq.valid = 1'b1; rq.fdiv = 6'd12; rq.idiv = 6'd5; lk = 1'b0;
    tick(); chk("midrst_accept", {o_fdiv, o_idiv}, {6'd12, 6'd5});
    rq.valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("midrst_in_wait", o_pll_reset, 0);
    rstn = 1'b0;
    tick(); chk("midrst", dvec(), {1'b1, 1'b0, 1'b0, 1'b0, 6'd51, 6'd58});
    rstn = 1'b1;

    // Random traffic against the model.
    rstn = 1'b0; tick(); rstn = 1'b1;
    mchk = 1'b1;
    begin
      bit lowmode = 1'b0;
      for (int k = 0; k < 4000; k++) begin
        if (k % 200 == 0) lowmode = ($urandom_range(0, 2) == 0);
        if (lowmode) lk = lk ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 3) == 0);
        else if ($urandom_range(0, 7) == 0) lk = ~lk;
        rq.valid = ($urandom_range(0, 5) == 0);
        rq.fdiv = 6'($urandom);
        rq.idiv = 6'($urandom);
        rstn = ($urandom_range(0, 499) != 0);
        tick();
      end
    end
    mchk = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
